// File: rtl/ulbf_rx_pkg.sv
// Shared types and sizing for the RX capture block: state encoding, RAM word
// geometry and frame-count width.
package ulbf_rx_pkg;

  localparam int STATE_W           = 2;
  localparam int RAM_DEPTH_DEFAULT = 8192;
  localparam int WORD_W            = 64;
  localparam int NITER_W           = 12;
  localparam int ADDR_W            = 16;
  localparam int CNT_W             = 16;
  localparam int WE_W              = WORD_W / 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ulbf_rx_capture_if.sv
// Stream-in / RAM-out bundle of the RX capture block. The slave modport is the
// capture block itself; the master modport is its environment.
interface ulbf_rx_capture_if;
  import ulbf_rx_pkg::*;

  logic [WORD_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              ram_en;
  logic [WE_W-1:0]   ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_din;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready, ram_en, ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/ulbf_rx_capture.sv
// Captures niter stream frames into the RX RAM, one 64-bit word per beat, and
// flags completion. A soft reset returns the block to IDLE for the next run.
module ulbf_rx_capture
  import ulbf_rx_pkg::*;
#(
  parameter int RAM_DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               slave_rst,
  input  logic [NITER_W-1:0] niter,
  ulbf_rx_capture_if.slave   bus,
  output logic               rxdone,
  output logic [CNT_W-1:0]   rxram_counter,
  output logic [STATE_W-1:0] rx_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  rx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [NITER_W-1:0] frame_cnt_q;
  logic [NITER_W-1:0] niter_q;
  logic [CNT_W-1:0]  count_q;
  logic              ram_en_q;
  logic [WE_W-1:0]   ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [WORD_W-1:0] ram_din_q;
  logic              tready;
  logic              beat;
  logic              last_frame;

  assign beat       = bus.s_axis_tvalid & tready;
  assign last_frame = (frame_cnt_q + NITER_W'(1)) == niter_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // niter is only consulted in IDLE; later frame counting uses the latched copy.
  always_comb begin
    state_d = state_q;
    if (slave_rst) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = (niter != '0) ? ST_CAPTURE : ST_DONE;
        ST_CAPTURE: if (beat && bus.s_axis_tlast && last_frame) state_d = ST_DONE;
        ST_DONE:    state_d = ST_DONE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tready   = (state_q == ST_CAPTURE) && !slave_rst;
    rxdone   = (state_q == ST_DONE);
    rx_state = state_q;
  end

  always_comb begin
    wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);
  end

  // RAM write port is registered: each accepted beat appears one cycle later.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q    <= '0;
      frame_cnt_q <= '0;
      niter_q     <= '0;
      count_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else if (slave_rst) begin
      wr_ptr_q    <= '0;
      frame_cnt_q <= '0;
      count_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
    end else begin
      ram_en_q <= beat;
      ram_we_q <= beat ? '1 : '0;
      if (state_q == ST_IDLE && niter != '0) niter_q <= niter;
      if (beat) begin
        ram_addr_q <= wr_ptr_q;
        ram_din_q  <= bus.s_axis_tdata;
        wr_ptr_q   <= wr_ptr_d;
        if (count_q != '1) count_q <= count_q + CNT_W'(1);
        if (bus.s_axis_tlast) frame_cnt_q <= frame_cnt_q + NITER_W'(1);
      end
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.ram_en        = ram_en_q;
  assign bus.ram_we        = ram_we_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_din       = ram_din_q;
  assign rxram_counter     = count_q;

endmodule

// File: doc/ulbf_rx_capture.md
ULBF_RX_CAPTURE -- requirements
Module: ulbf_rx_capture

Interface
REQ-001 Parameter RAM_DEPTH, 8192, number of 64-bit words in RX RAM; power of two, max 65536.
REQ-002 ap_clk  in  1  sole clock; all logic rising-edge.
REQ-003 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-004 slave_rst  in  1  soft reset from control block, active-high, sampled on ap_clk.
REQ-005 niter  in  12  number of frames to capture.
REQ-006 s_axis_tdata  in  64  RX sample word.
REQ-007 s_axis_tvalid  in  1  upstream word valid.
REQ-008 s_axis_tlast  in  1  last word of a frame.
REQ-009 s_axis_tready  out  1  block accepts a word.
REQ-010 ram_en  out  1  RX RAM port enable.
REQ-011 ram_we  out  8  RX RAM byte write enables.
REQ-012 ram_addr  out  16  RX RAM word address.
REQ-013 ram_din  out  64  RX RAM write data.
REQ-014 rxdone  out  1  capture of niter frames complete.
REQ-015 rxram_counter  out  16  words written since last reset.
REQ-016 rx_state  out  2  current state encoding (IDLE=0, CAPTURE=1, DONE=2).

Function
REQ-017 States IDLE, CAPTURE, DONE; encoding per REQ-016.
REQ-018 IDLE -> CAPTURE when slave_rst=0 and niter!=0; niter latched into internal niter_q on this transition.
REQ-019 IDLE -> DONE when slave_rst=0 and niter=0.
REQ-020 s_axis_tready = 1 only when state=CAPTURE and slave_rst=0 (combinational); beat = tvalid & tready.
REQ-021 Each beat: next cycle ram_en=1, ram_we=8'hFF, ram_addr=wr_ptr, ram_din=tdata (1-cycle registered latency); otherwise ram_en=0, ram_we=0, ram_din holds.
REQ-022 wr_ptr increments per beat; wraps from RAM_DEPTH-1 to 0.
REQ-023 rxram_counter increments per beat, updating in the same cycle ram_en asserts; saturates at 16'hFFFF.
REQ-024 Beat with tlast=1 increments frame_cnt (12-bit); if frame_cnt+1 = niter_q, next state DONE.
REQ-025 niter changes during CAPTURE or DONE have no effect.
REQ-026 DONE: tready=0, rxdone=1, counters frozen; exit only via slave_rst or ap_rst_n.
REQ-027 slave_rst=1 in any state: next cycle state=IDLE, wr_ptr=0, frame_cnt=0, rxram_counter=0, rxdone=0, ram_en=0, ram_we=0; no beat accepted in the assertion cycle.
REQ-028 Final tlast beat: its RAM write still issues in the cycle rxdone first asserts.
REQ-029 tvalid with tready=0 is ignored; no data loss required of this block (upstream holds).

Reset
REQ-030 ap_rst_n=0 asynchronously forces state=IDLE, wr_ptr=0, frame_cnt=0, niter_q=0, rxram_counter=0, rxdone=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, s_axis_tready=0.
REQ-031 After ap_rst_n release, block waits in IDLE until slave_rst=0 (REQ-018/019).

Structure
REQ-032 Package ulbf_rx_pkg holds state enum, state width, RAM_DEPTH default, RAM word width 64, niter width 12.
REQ-033 No sub-module; single flat module with one FSM process, one datapath process.

Verification
REQ-034 niter=2, frames of 4 words (tlast on 4th), tvalid continuous -> 8 writes, addr 0..7, rxram_counter=8, rxdone=1 the cycle after 8th write issues... rxdone and 8th ram_en in same cycle, tready=0 thereafter.
REQ-035 niter=0, slave_rst 1->0 -> rx_state=DONE next cycle, rxdone=1, no ram_en.
REQ-036 RAM_DEPTH=16, niter=1, 20-word frame -> addrs 0..15,0..3, rxram_counter=20, rxdone=1.
REQ-037 slave_rst pulsed after 3 of 5 words with tvalid high -> no write in pulse cycle, counters 0, rxdone=0; restart writes from addr 0.
REQ-038 niter=3 at start, changed to 1 mid-frame -> capture ends after 3rd tlast, not 1st.
REQ-039 ap_rst_n asserted mid-CAPTURE (async, off clock edge) -> all outputs zero immediately, rx_state=IDLE.
